serial_frame_ctrl: RTL and testbench

//   Transaction controller directly upstream of the WIDTH-bit serial shift engine.
//   - Accepts one word per valid/ready request and frames it with chip-select setup/hold.
//   - Drives the engine's trig/data_in and generates its bit-rate tick plus an SPI-style sck.
//   - Captures the engine's received word and returns it on a valid/ready response port.

---
 rtl/serial_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_serial_frame_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_ctrl.sv
`default_nettype none
// serial_frame_ctrl: frames one word per request with cs_n setup/hold, drives the shift
// engine's trig/tick/sck and returns the captured word with a watchdog error flag.
module serial_frame_ctrl #(
  parameter int WIDTH    = 32,
  parameter int DIV      = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 1
) (
  input  logic             CLKB,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             eng_trig,
  output logic [WIDTH-1:0] eng_data_in,
  input  logic             eng_ready,
  input  logic [WIDTH-1:0] eng_data_out,
  output logic             tick,
  output logic             sck,
  output logic             cs_n
);
  localparam int DW   = $clog2(DIV);
  localparam int BW   = $clog2(WIDTH + 1);
  localparam int PMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PW   = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ph_cnt_q, ph_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             wd_q, wd_d;
  logic [WIDTH-1:0] eng_data_in_q, eng_data_in_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  always_ff @(posedge CLKB or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      ph_cnt_q      <= '0;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      wd_q          <= 1'b0;
      eng_data_in_q <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_cnt_q      <= ph_cnt_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      wd_q          <= wd_d;
      eng_data_in_q <= eng_data_in_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ph_cnt_d      = ph_cnt_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    wd_d          = wd_q;
    eng_data_in_d = eng_data_in_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    eng_trig      = 1'b0;
    tick          = 1'b0;
    sck           = 1'b0;
    cs_n          = 1'b1;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          eng_data_in_d = req_data;
          ph_cnt_d      = '0;
          state_d       = S_SETUP;
        end
      end
      S_SETUP: begin
        cs_n = 1'b0;
        if (ph_cnt_q == PW'(CS_SETUP - 1)) begin
          ph_cnt_d = '0;
          state_d  = S_LOAD;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        cs_n      = 1'b0;
        eng_trig  = 1'b1;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        wd_d      = 1'b0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        cs_n = 1'b0;
        if (bit_cnt_q != BW'(WIDTH)) begin
          tick = (div_cnt_q == DW'(DIV - 1));
          sck  = (div_cnt_q >= DW'(DIV / 2));
          if (tick) begin
            div_cnt_d = '0;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end else if (eng_ready || wd_q) begin
          // wd_q marks the second post-shift clock: a still-busy engine is flagged, not waited on
          rsp_data_d = eng_data_out;
          rsp_err_d  = !eng_ready;
          ph_cnt_d   = '0;
          state_d    = S_HOLD;
        end else begin
          wd_d = 1'b1;
        end
      end
      S_HOLD: begin
        cs_n = 1'b0;
        if (ph_cnt_q == PW'(CS_HOLD - 1)) begin
          ph_cnt_d = '0;
          state_d  = S_DONE;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign eng_data_in = eng_data_in_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_ctrl.sv
`default_nettype none
// tb_serial_frame_ctrl: controller plus a loopback shift-engine model; responses are checked
// against the request words and the framing timing implied by the parameters.
module tb_serial_frame_ctrl;
  localparam int WIDTH    = 8;
  localparam int DIV      = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 1;
  localparam int LAT_OK   = CS_SETUP + 1 + WIDTH * DIV + 1 + CS_HOLD;
  localparam int LAT_ERR  = LAT_OK + 1;
  localparam int BOUND    = 200;

  logic             CLKB = 1'b0;
  logic             RST  = 1'b0;
  logic             req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic             eng_trig, eng_ready, tick, sck, cs_n;
  logic [WIDTH-1:0] req_data, rsp_data, eng_data_in, eng_data_out;

  serial_frame_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .CLKB(CLKB), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_trig(eng_trig), .eng_data_in(eng_data_in), .eng_ready(eng_ready),
    .eng_data_out(eng_data_out), .tick(tick), .sck(sck), .cs_n(cs_n)
  );

  always #5 CLKB = ~CLKB;

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;
  int hs_cyc = 0;
  int rsp_count = 0;
  logic stuck = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLKB) cyc_n <= cyc_n + 1;

  // Shift engine with tx looped to rx: after WIDTH rotations the register holds the sent word.
  logic [WIDTH-1:0] eng_sr;
  logic             eng_rdy_m;
  int               eng_cnt;
  always @(posedge CLKB or negedge RST) begin
    if (!RST) begin
      eng_sr    <= '0;
      eng_rdy_m <= 1'b1;
      eng_cnt   <= 0;
    end else if (eng_trig) begin
      eng_sr    <= eng_data_in;
      eng_rdy_m <= 1'b0;
      eng_cnt   <= 0;
    end else if (tick && !eng_rdy_m) begin
      eng_sr  <= {eng_sr[WIDTH-2:0], eng_sr[WIDTH-1]};
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == WIDTH - 1) eng_rdy_m <= 1'b1;
    end
  end
  assign eng_ready    = stuck ? 1'b0 : eng_rdy_m;
  assign eng_data_out = eng_sr;

  // Per-frame framing monitor
  int   low_cnt = 0, n_tick = 0, n_rise = 0, n_trig = 0, since_evt = 0, since_rise = 0;
  int   high_gap = 100, frames_seen = 0, stray_tick = 0, stray_trig = 0;
  logic prev_cs = 1'b1, prev_sck = 1'b0;
  always @(negedge CLKB) begin
    if (!RST) begin
      low_cnt = 0; n_tick = 0; n_rise = 0; n_trig = 0; since_evt = 0; since_rise = 0;
      high_gap = 100; prev_cs = 1'b1; prev_sck = 1'b0;
    end else begin
      if (cs_n && tick) stray_tick++;
      if (cs_n && eng_trig) stray_trig++;
      if (!cs_n) begin
        if (prev_cs) check("cs_gap_between_frames", 32'(high_gap >= 1), 32'd1);
        low_cnt++;
        if (eng_trig) begin n_trig++; since_evt = 0; end
        else since_evt++;
        if (sck && !prev_sck) begin n_rise++; since_rise = 0; end
        else since_rise++;
        if (tick) begin
          check("tick_spacing", 32'(since_evt), 32'(DIV));
          check("sck_rise_to_tick", 32'(since_rise), 32'(DIV - DIV / 2 - 1));
          n_tick++;
          since_evt = 0;
        end
      end else if (!prev_cs) begin
        frames_seen++;
        check("ticks_per_frame", 32'(n_tick), 32'(WIDTH));
        check("sck_rises_per_frame", 32'(n_rise), 32'(WIDTH));
        check("trig_per_frame", 32'(n_trig), 32'd1);
        check("cs_low_clocks", 32'(low_cnt), stuck ? 32'(LAT_ERR) : 32'(LAT_OK));
        low_cnt = 0; n_tick = 0; n_rise = 0; n_trig = 0; since_evt = 0; since_rise = 0;
        high_gap = 1;
      end else begin
        high_gap++;
      end
      prev_cs  = cs_n;
      prev_sck = sck;
    end
  end

  task automatic send(input logic [WIDTH-1:0] w);
    int n = 0;
    while (!req_ready && n < BOUND) begin @(negedge CLKB); n++; end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_data  = w;
    exp_q.push_back(w);
    hs_cyc = cyc_n + 1;
    @(negedge CLKB);
    req_valid = 1'b0;
  endtask

  // hold < 0: rsp_ready is already high and the caller owns it
  task automatic get_rsp(input int exp_lat, input logic exp_err, input int hold);
    int n = 0;
    logic [WIDTH-1:0] w = '0;
    logic [WIDTH-1:0] d0;
    logic stable = 1'b1;
    while (!rsp_valid && n < BOUND) begin @(negedge CLKB); n++; end
    check("rsp_latency", 32'(cyc_n - hs_cyc), 32'(exp_lat));
    if (exp_q.size() > 0) w = exp_q.pop_front();
    check("rsp_data", 32'(rsp_data), 32'(w));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    d0 = rsp_data;
    rsp_count++;
    if (hold >= 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge CLKB);
        if (!(rsp_valid === 1'b1 && rsp_data === d0 && rsp_err === exp_err &&
              cs_n === 1'b1 && tick === 1'b0)) stable = 1'b0;
      end
      if (hold > 0) check("done_stable", 32'(stable), 32'd1);
      rsp_ready = 1'b1;
      @(negedge CLKB);
      rsp_ready = 1'b0;
    end else begin
      @(negedge CLKB);
    end
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("req_ready_after_rsp", 32'(req_ready), 32'd1);
    check("rsp_err_cleared", 32'(rsp_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [WIDTH-1:0] w;
    req_valid = 1'b0; req_data = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge CLKB);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_trig", 32'(eng_trig), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_eng_data_in", 32'(eng_data_in), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    RST = 1'b1;
    @(negedge CLKB);

    // Single frame
    send(8'hA5);
    get_rsp(LAT_OK, 1'b0, 0);

    // Back-to-back words with rsp_ready held high; the second word waits for IDLE
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_data  = 8'h00;
    exp_q.push_back(8'h00);
    hs_cyc = cyc_n + 1;
    @(negedge CLKB);
    req_data = 8'hFF;
    check("busy_req_ready", 32'(req_ready), 32'd0);
    repeat (10) @(negedge CLKB);
    check("busy_data_not_sampled", 32'(eng_data_in), 32'h00);
    check("busy_req_ready_mid", 32'(req_ready), 32'd0);
    get_rsp(LAT_OK, 1'b0, -1);
    check("b2b_second_accept", 32'(req_ready), 32'd1);
    exp_q.push_back(8'hFF);
    hs_cyc = cyc_n + 1;
    @(negedge CLKB);
    req_valid = 1'b0;
    get_rsp(LAT_OK, 1'b0, -1);
    rsp_ready = 1'b0;

    // Consumer stalls 10 clocks in DONE
    send(8'h5A);
    get_rsp(LAT_OK, 1'b0, 10);

    // Engine never reports ready: watchdog error, then clean recovery
    stuck = 1'b1;
    send(8'hC3);
    get_rsp(LAT_ERR, 1'b1, 2);
    stuck = 1'b0;
    send(8'h96);
    get_rsp(LAT_OK, 1'b0, 0);

    // Asynchronous reset after the 3rd tick aborts the frame
    send(8'h71);
    n = 0;
    while (n < 3 && cyc_n < hs_cyc + BOUND) begin
      @(negedge CLKB);
      if (tick) n++;
    end
    check("third_tick_seen", 32'(n), 32'd3);
    #2 RST = 1'b0;
    #1;
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sck", 32'(sck), 32'd0);
    check("abort_tick", 32'(tick), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    void'(exp_q.pop_front());
    @(negedge CLKB);
    @(negedge CLKB);
    #2 RST = 1'b1;
    @(negedge CLKB);
    send(8'h3C);
    get_rsp(LAT_OK, 1'b0, 0);

    // Random words and consumer stalls
    for (int i = 0; i < 6; i++) begin
      w = WIDTH'($urandom);
      send(w);
      get_rsp(LAT_OK, 1'b0, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge CLKB);
    check("no_tick_outside_frame", 32'(stray_tick), 32'd0);
    check("no_trig_outside_frame", 32'(stray_trig), 32'd0);
    check("frames_completed", 32'(frames_seen), 32'(rsp_count));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
